// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word requests
// to instruction memory and hands fetched words downstream over valid/ready.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [10:0] opcode,
  output logic [63:0] pc_out,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
  } fetch_rsp_t;

  state_t      state, state_nxt;
  fetch_rsp_t  rsp;
  logic [63:0] pc, fetch_addr, redirect_pc, tgt, pc_nxt;
  logic        ld_pc, capture, save_redir, accept;

  assign tgt = {branch_target[63:2], 2'b00};

  // Redirect beats every other transition; a stale ack is simply dropped.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ld_pc      = 1'b0;
    capture    = 1'b0;
    save_redir = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        ld_pc     = 1'b1;
        pc_nxt    = RESET_PC;
      end
      FETCH: begin
        if (branch_taken) begin
          if (imem_ack) begin
            ld_pc  = 1'b1;
            pc_nxt = tgt;
          end else begin
            save_redir = 1'b1;
            state_nxt  = FLUSH;
          end
        end else if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          ld_pc     = 1'b1;
          pc_nxt    = tgt;
          state_nxt = FETCH;
        end else if (instr_ready) begin
          accept    = 1'b1;
          ld_pc     = 1'b1;
          pc_nxt    = pc_out + 64'd4;
          state_nxt = FETCH;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          ld_pc     = 1'b1;
          pc_nxt    = branch_taken ? tgt : redirect_pc;
          state_nxt = FETCH;
        end else if (branch_taken) begin
          save_redir = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_addr   <= RESET_PC;
      redirect_pc  <= 64'h0;
      rsp          <= '0;
      misalign_err <= 1'b0;
      instr_count  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (ld_pc) begin
        pc         <= pc_nxt;
        fetch_addr <= pc_nxt;
      end
      if (save_redir) redirect_pc <= tgt;
      if (capture) begin
        rsp.word <= imem_rdata;
        rsp.pc   <= fetch_addr;
      end
      if (accept) instr_count <= instr_count + 32'd1;
      if (branch_taken && state != IDLE && branch_target[1:0] != 2'b00)
        misalign_err <= 1'b1;
    end
  end

  assign imem_req    = (state == FETCH) || (state == FLUSH);
  assign imem_addr   = fetch_addr;
  assign instr_valid = (state == HOLD);
  assign instr       = rsp.word;
  assign pc_out      = rsp.pc;
  assign opcode      = rsp.word[31:21];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory responder plus a scoreboard
// of expected fetch PCs popped on every downstream accept.
module tb_fetch_unit;

  logic        CLK, resetl;
  logic        imem_req, imem_ack;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] pc_out;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        misalign_err;
  logic [31:0] instr_count;

  int ncmp = 0;
  int nerr = 0;
  int lat  = 0;
  int cnt  = 0;
  logic [63:0] sb[$];

  fetch_unit #(.RESET_PC(64'h100)) dut (
    .CLK(CLK), .resetl(resetl),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .pc_out(pc_out), .branch_taken(branch_taken), .branch_target(branch_target),
    .misalign_err(misalign_err), .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0] ^ {a[12:2], 21'h0};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: acks after lat extra cycles of a continuous request.
  always @(negedge CLK) begin
    if (imem_req) begin
      if (cnt >= lat) begin
        imem_ack   <= 1'b1;
        imem_rdata <= word_of(imem_addr);
        cnt        <= 0;
      end else begin
        imem_ack   <= 1'b0;
        imem_rdata <= 32'h0;
        cnt        <= cnt + 1;
      end
    end else begin
      imem_ack   <= 1'b0;
      imem_rdata <= 32'h0;
      cnt        <= 0;
    end
  end

  // Scoreboard: every real accept must match the next expected PC.
  always @(negedge CLK) begin
    if (resetl && instr_valid && instr_ready && !branch_taken) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        logic [63:0] p;
        p = sb.pop_front();
        chk("sb_pc", pc_out, p);
        chk("sb_instr", 64'(instr), 64'(word_of(p)));
        chk("sb_opcode", 64'(opcode), 64'(word_of(p) >> 21));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(string tag, int max);
    for (int i = 0; i < max && !imem_req; i++) step();
    chk(tag, 64'(imem_req), 64'd1);
  endtask

  task automatic wait_valid(string tag, int max);
    for (int i = 0; i < max && !instr_valid; i++) step();
    chk(tag, 64'(instr_valid), 64'd1);
  endtask

  task automatic wait_cnt(string tag, logic [31:0] n, int max);
    for (int i = 0; i < max && instr_count != n; i++) step();
    chk(tag, 64'(instr_count), 64'(n));
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'h100);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_opcode", 64'(opcode), 64'd0);
    chk("rst_pc_out", pc_out, 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetl = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #3 resetl = 1'b0;
    #1 chk_reset_vals();
    step();
    resetl = 1'b1;

    // Sequential fetch, zero-wait memory, ready high: 2 cycles per instruction
    lat = 0;
    sb.push_back(64'h100); sb.push_back(64'h104); sb.push_back(64'h108);
    wait_req("first_req", 4);
    chk("first_addr", imem_addr, 64'h100);
    instr_ready = 1'b1;
    step(); chk("v100", 64'(instr_valid), 64'd1); chk("pc100", pc_out, 64'h100);
    step(); chk("req104", 64'(imem_req), 64'd1); chk("addr104", imem_addr, 64'h104);
    step(); chk("pc104", pc_out, 64'h104);
    step(); chk("addr108", imem_addr, 64'h108);
    step(); chk("pc108", pc_out, 64'h108);
    step(); chk("count3", 64'(instr_count), 64'd3);
    instr_ready = 1'b0;

    // Backpressure: held word stays put for 4 cycles
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_pc", pc_out, 64'h10C);
      chk("stall_instr", 64'(instr), 64'(word_of(64'h10C)));
    end
    lat = 3; instr_ready = 1'b1; sb.push_back(64'h10C);
    step(); instr_ready = 1'b0;
    chk("count4", 64'(instr_count), 64'd4);
    // Wait states: address must hold until the ack
    for (int i = 0; i < 10 && !instr_valid; i++) begin
      chk("wait_addr", imem_addr, 64'h110);
      step();
    end
    chk("wait_valid", 64'(instr_valid), 64'd1);
    chk("wait_pc", pc_out, 64'h110);
    chk("wait_count", 64'(instr_count), 64'd4);

    // Redirect in HOLD with ready: instruction dropped
    branch_taken = 1'b1; branch_target = 64'h2000; instr_ready = 1'b1;
    step(); branch_taken = 1'b0; instr_ready = 1'b0;
    chk("hold_redir_count", 64'(instr_count), 64'd4);
    chk("hold_redir_addr", imem_addr, 64'h2000);
    chk("hold_redir_valid", 64'(instr_valid), 64'd0);

    // Redirect with request outstanding, then a newer one in FLUSH
    branch_taken = 1'b1; branch_target = 64'h2800;
    step();
    chk("flush_req", 64'(imem_req), 64'd1);
    chk("flush_addr", imem_addr, 64'h2000);
    branch_target = 64'h3000;
    step(); branch_taken = 1'b0;
    for (int i = 0; i < 10 && imem_addr == 64'h2000; i++) begin
      chk("flush_no_valid", 64'(instr_valid), 64'd0);
      step();
    end
    chk("flush_new_addr", imem_addr, 64'h3000);
    chk("flush_new_req", 64'(imem_req), 64'd1);
    sb.push_back(64'h3000); instr_ready = 1'b1;
    wait_cnt("count5", 32'd5, 20);
    instr_ready = 1'b0;

    // Redirect and ack in the same FETCH cycle, misaligned target
    lat = 0; branch_taken = 1'b1; branch_target = 64'h2006;
    step(); branch_taken = 1'b0;
    chk("same_addr", imem_addr, 64'h2004);
    chk("same_valid", 64'(instr_valid), 64'd0);
    chk("misalign_set", 64'(misalign_err), 64'd1);
    sb.push_back(64'h2004); sb.push_back(64'h2008); instr_ready = 1'b1;
    wait_cnt("count7", 32'd7, 20);
    chk("misalign_sticky", 64'(misalign_err), 64'd1);
    instr_ready = 1'b0; lat = 1000;

    // Async reset mid-FLUSH
    step();
    branch_taken = 1'b1; branch_target = 64'h4000;
    step(); branch_taken = 1'b0;
    chk("pre_rst_req", 64'(imem_req), 64'd1);
    #2 resetl = 1'b0;
    #1 chk_reset_vals();
    lat = 0;
    step(); resetl = 1'b1;

    // PC wrap at the top of the address space
    wait_req("wrap_req", 4);
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); branch_taken = 1'b0;
    chk("wrap_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_misalign", 64'(misalign_err), 64'd0);
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFC); instr_ready = 1'b1;
    wait_cnt("wrap_count", 32'd1, 20);
    chk("wrap_addr", imem_addr, 64'h0);
    instr_ready = 1'b0;

    // Counter wrap from a forced preload
    force dut.instr_count = 32'hFFFF_FFFF;
    #1 release dut.instr_count;
    wait_valid("cw_valid", 10);
    chk("cw_pc", pc_out, 64'h0);
    chk("cw_pre", 64'(instr_count), 64'hFFFF_FFFF);
    sb.push_back(64'h0); instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    chk("cw_wrap", 64'(instr_count), 64'd0);

    step(); step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
